// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide unit controller for the E stage.
//
// Computes the MULT/MULTU/DIV/DIVU result in the cycle the operation is
// accepted. That result is held in pending registers p_hi/p_lo. The unit
// then stays busy for a fixed number of cycles before the result becomes
// architecturally visible in hi/lo. Every write to hi/lo first saves the
// old pair in s_hi/s_lo. This lets an exception handler roll back the most
// recent hi/lo update.
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (1..15)
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous active-high reset
//   start      an md instruction is valid in E this cycle
//   op         0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   a, b       rs / rt operand values
//   stop       exception in flight: accept nothing new, abort a running op
//   restore    roll hi/lo back to the shadow copy (aborts a running op)
//   busy       an operation is in progress
//   stall_req  stall D-stage consumers of hi/lo and further md ops
//   hi, lo     architectural HI/LO
module md_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        stop,
  input  logic        restore,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] p_hi, p_lo, s_hi, s_lo;

  logic        is_md;
  logic        div_zero, div_ovf;
  logic [63:0] prod_s, prod_u;
  logic signed [63:0] a_sx, b_sx;
  logic signed [31:0] a_s, b_safe_s, q_s, r_s;
  logic [31:0] b_safe_u, q_u, r_u;
  logic [31:0] res_hi, res_lo;

  assign is_md = (op == OP_MULT) || (op == OP_MULTU) ||
                 (op == OP_DIV)  || (op == OP_DIVU);

  // Multipliers: sign-extend to 64 bits for MULT, zero-extend for MULTU.
  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'b0, a} * {32'b0, b};

  // The divide-by-zero and INT_MIN/-1 cases are resolved by the result mux.
  // The divider is fed a divisor of 1 for those cases so it never sees an
  // unrepresentable quotient.
  assign div_zero = (b == 32'h0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  assign a_s      = $signed(a);
  assign b_safe_s = (div_zero || div_ovf) ? 32'sd1 : $signed(b);
  assign q_s      = a_s / b_safe_s;
  assign r_s      = a_s % b_safe_s;

  assign b_safe_u = div_zero ? 32'd1 : b;
  assign q_u      = a / b_safe_u;
  assign r_u      = a % b_safe_u;

  // Result selection; lo carries the low product half or the quotient.
  always_comb begin
    res_hi = 32'h0;
    res_lo = 32'h0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          res_hi = 32'h0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = r_s;
          res_lo = q_s;
        end
      end
      OP_DIVU: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = r_u;
          res_lo = q_u;
        end
      end
      default: begin
        res_hi = 32'h0;
        res_lo = 32'h0;
      end
    endcase
  end

  // restore outranks everything. After it, stop aborts a running op. A new
  // op is accepted only from IDLE, so start is ignored while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi    <= 32'h0;
      lo    <= 32'h0;
      p_hi  <= 32'h0;
      p_lo  <= 32'h0;
      s_hi  <= 32'h0;
      s_lo  <= 32'h0;
    end else if (restore) begin
      hi    <= s_hi;
      lo    <= s_lo;
      state <= IDLE;
      cnt   <= 4'd0;
    end else if (state == RUN) begin
      if (stop) begin
        state <= IDLE;
        cnt   <= 4'd0;
      end else if (cnt == 4'd1) begin
        s_hi  <= hi;
        s_lo  <= lo;
        hi    <= p_hi;
        lo    <= p_lo;
        state <= IDLE;
        cnt   <= 4'd0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end else if (start && !stop) begin
      case (op)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          p_hi  <= res_hi;
          p_lo  <= res_lo;
          cnt   <= ((op == OP_MULT) || (op == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
          state <= RUN;
        end
        OP_MTHI: begin
          s_hi <= hi;
          s_lo <= lo;
          hi   <= a;
        end
        OP_MTLO: begin
          s_hi <= hi;
          s_lo <= lo;
          lo   <= a;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign stall_req = busy | (start & is_md & ~stop);

endmodule
